bank_serializer: RTL and testbench
==================================

# bank_serializer

Drains a packed bank of equal-width words, such as the pairwise-sum output of the adder tree stage, onto a one-word-per-beat valid/ready stream. Word 0 (LSBs of the bank) is sent first. The block sits downstream of the bank-parallel datapath and feeds narrow consumers such as FIFOs, UARTs or memory writers. It sustains one word per cycle with no bubble between consecutive banks.

## Interface
Parameters:
- WORD_SIZE, 9, width of one output word (matches the adder-tree sum width for 8-bit inputs).
- BANK_SIZE, 8, words per bank; must be >= 1.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  bank on in_data is valid.
- in_ready  output  1  block accepts a bank this cycle.
- in_data  input  WORD_SIZE*BANK_SIZE  packed bank; word i is in_data[(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WORD_SIZE  current word.
- out_index  output  IDX_W  index of the current word in its bank; IDX_W = max(1, clog2(BANK_SIZE)).
- out_last  output  1  current word is word BANK_SIZE-1.
- busy  output  1  a bank is held (state SEND).

## Operation
- Two states: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture in_data into the bank register, clear idx to 0, go to SEND.
- SEND:
  - out_valid=1, out_data=bank word idx, out_index=idx, out_last=(idx==BANK_SIZE-1).
  - Output beat = out_valid&&out_ready.
  - Beat with out_last=0: idx increments.
  - Beat with out_last=1 and in_valid=1: capture the new bank, idx=0, stay in SEND (back-to-back).
  - Beat with out_last=1 and in_valid=0: go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready; no other combinational input-to-output paths exist.
- in_valid in SEND outside the final beat is ignored. The upstream holds it per valid/ready rules.
- While out_valid=1 and out_ready=0, out_data, out_index and out_last stay stable.
- Once asserted, out_valid does not drop until the beat occurs.
- BANK_SIZE=1: every word has out_last=1, and idx stays 0.
- The bank register loads only on an input handshake. It is never modified while words are being sent.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, bank register=0.
- Latency: bank accepted at edge N gives word 0 on out_* after edge N, visible in cycle N+1.
- Throughput: with out_ready held high, one word per cycle and BANK_SIZE cycles per bank, with zero idle cycles between banks.
- With in_valid low after the last beat, the block is in IDLE the next cycle, with out_valid=0.
- Reset asserted mid-bank: the remaining words are dropped, and outputs go to reset values immediately and asynchronously. There is no resume after reset.
- Reset deasserts synchronously to clk via the upstream reset synchronizer.

## Structure
- Shared package bank_pkg:
  - state enum {IDLE, SEND}.
  - Index-width function idx_w(BANK_SIZE) = max(1, clog2(BANK_SIZE)).
  - Word/bank width helpers reused by the adder-tree wrapper.
- Single module. No sub-module: the index counter and word mux are a few lines each.
- Word select uses an indexed part-select on the bank register, not a shift register, so stalls cost no power.

## Test plan
- Single bank, out_ready=1: WORD_SIZE=9, BANK_SIZE=8, in_data words 0x001..0x008.
  - Expect out_data 1..8 in cycles N+1..N+8, out_index 0..7, out_last only on 8.
  - Expect in_ready=0 in cycles N+1..N+7, then IDLE.
- Back-to-back: second bank 0x1FF..0x1F8 presented with in_valid high throughout.
  - Expect 16 consecutive beats with no bubble, the second bank captured on the first bank's out_last beat, and in_ready=1 only in that cycle.
- Backpressure: drop out_ready for 3 cycles at idx=3.
  - Expect out_data=0x004 and out_index=3 held stable, out_valid=1, no index advance.
  - Expect in_valid ignored during the stall.
- Reset mid-bank: assert rst at idx=5.
  - Expect out_valid=0, out_data=0, busy=0, in_ready=1 immediately.
  - After release, the next bank starts at word 0.
- BANK_SIZE=1, WORD_SIZE=4: stream 0xA, 0x5, 0xF with continuous valid/ready.
  - Expect one word per cycle, out_last=1 and out_index=0 on every beat.
- Random valid/ready on both sides over 1000 banks: the scoreboard sees every word, in order, with exactly one out_last per bank.

Source files
------------

// File: rtl/bank_pkg.sv
// bank_pkg
//   Shared types and width helpers for the bank-parallel datapath and its
//   serializer. The adder-tree wrapper reuses word_w/bank_w to size its
//   output bank so both sides agree on the packing.
package bank_pkg;

   typedef enum logic {IDLE, SEND} state_t;

   localparam int DEF_WORD_SIZE = 9;
   localparam int DEF_BANK_SIZE = 8;

   // Index width: a single-word bank still carries a 1-bit index.
   function automatic int idx_w(input int bank_size);
      return (bank_size <= 1) ? 1 : $clog2(bank_size);
   endfunction

   function automatic int word_w(input int in_w);
      return in_w + 1;  // pairwise sum of two in_w-bit operands
   endfunction

   function automatic int bank_w(input int word_size, input int bank_size);
      return word_size * bank_size;
   endfunction

endpackage

// File: rtl/bank_serializer.sv
// bank_serializer
//   Drains a packed bank of BANK_SIZE words onto a one-word-per-beat
//   valid/ready stream, word 0 (bank LSBs) first. Sustains one word per
//   cycle, including across banks: the next bank is captured on the final
//   beat of the current one.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  bank handshake; in_ready is combinational from
//                      out_ready on the final beat
//   in_data            packed bank, word i at [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
//   out_valid/out_ready word handshake
//   out_data           current word
//   out_index          position of out_data within its bank
//   out_last           out_data is word BANK_SIZE-1
//   busy               a bank is held
module bank_serializer
   import bank_pkg::*;
#(
   parameter  int WORD_SIZE = DEF_WORD_SIZE,
   parameter  int BANK_SIZE = DEF_BANK_SIZE,
   localparam int IDX_W     = idx_w(BANK_SIZE),
   localparam int BANK_W    = bank_w(WORD_SIZE, BANK_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BANK_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_data,
   output logic [IDX_W-1:0]     out_index,
   output logic                 out_last,
   output logic                 busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_SIZE - 1);

   state_t             state_q, state_nxt;
   logic [IDX_W-1:0]   idx_q, idx_nxt;
   logic [BANK_W-1:0]  bank_q;
   logic               load_bank;
   logic               sending;
   logic               at_last;
   logic               beat;

   assign sending = (state_q == SEND);
   assign at_last = (idx_q == LAST_IDX);
   assign beat    = sending && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         bank_q  <= '0;
      end else begin
         state_q <= state_nxt;
         idx_q   <= idx_nxt;
         // Bank register only changes on an input handshake; stalls leave
         // it and the word mux untouched.
         if (load_bank) bank_q <= in_data;
      end
   end

   always_comb begin
      state_nxt = state_q;
      idx_nxt   = idx_q;
      load_bank = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_bank = 1'b1;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (beat) begin
               if (!at_last) begin
                  idx_nxt = idx_q + 1'b1;
               end else begin
                  // Final beat frees the bank register this same edge, so
                  // a waiting bank is taken with no bubble.
                  in_ready = 1'b1;
                  idx_nxt  = '0;
                  if (in_valid) load_bank = 1'b1;
                  else          state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are forced to zero outside SEND so a reset mid-bank shows
   // reset values immediately.
   assign out_valid = sending;
   assign busy      = sending;
   assign out_index = idx_q;
   assign out_last  = sending && at_last;
   assign out_data  = sending ? bank_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE]
                              : '0;

endmodule

// File: tb/tb_bank_serializer.sv
// tb_bank_serializer
//   Checks bank_serializer (9x8 and 4x1 configurations) against a queue
//   scoreboard: every accepted bank expands into its words; the stream must
//   present the queue head whenever the queue is non-empty.
module tb_bank_serializer;

   localparam int W = 9;
   localparam int B = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [W*B-1:0] in_data;
   logic [W-1:0]  out_data;
   logic [2:0]    out_index;

   logic          in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
   logic [3:0]    in_data1, out_data1;
   logic [0:0]    out_index1;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] d;
      int           idx;
      bit           last;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   bank_serializer #(.WORD_SIZE(W), .BANK_SIZE(B)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .busy(busy)
   );

   bank_serializer #(.WORD_SIZE(4), .BANK_SIZE(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_index(out_index1), .out_last(out_last1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: evaluated mid-cycle, then updated for the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         bit exp_v, exp_rdy;
         exp_v   = (q.size() != 0);
         exp_rdy = !exp_v || (out_ready && q[0].last);
         chk("out_valid", out_valid, exp_v);
         chk("busy", busy, exp_v);
         chk("in_ready", in_ready, exp_rdy);
         if (exp_v) begin
            chk("out_data", out_data, q[0].d);
            chk("out_index", out_index, q[0].idx);
            chk("out_last", out_last, q[0].last);
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && exp_rdy)
            for (int i = 0; i < B; i++)
               q.push_back('{d: in_data[i*W +: W], idx: i, last: (i == B-1)});
      end
   end

   function automatic logic [W*B-1:0] mk_bank(input int base, input int step);
      logic [W*B-1:0] v;
      for (int i = 0; i < B; i++) v[i*W +: W] = W'(base + step*i);
      return v;
   endfunction

   task automatic send_bank(input logic [W*B-1:0] d);
      bit hs;
      int cnt;
      in_valid = 1'b1;
      in_data  = d;
      cnt = 0;
      do begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk); #1;
         cnt++;
      end while (!hs && cnt < 300);
      if (!hs) chk("hs_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int cnt = 0;
      while (q.size() != 0 && cnt < 300) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      logic [3:0] w1 [3];
      bit prod_done;
      rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0;
      in_valid1 = 0; in_data1 = '0; out_ready1 = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Single bank, words 1..8, first word visible right after accept.
      out_ready = 1'b1;
      send_bank(mk_bank(1, 1));
      chk("lat_data", out_data, 9'h001);
      chk("lat_index", out_index, 0);
      wait_idle();
      @(posedge clk); #1;
      chk("idle_valid", out_valid, 0);

      // Back-to-back: no bubble between banks.
      send_bank(mk_bank(1, 1));
      send_bank(mk_bank(9'h1FF, -1));
      chk("b2b_data0", out_data, 9'h1FF);
      wait_idle();

      // Backpressure at idx 3 with in_valid asserted during the stall.
      send_bank(mk_bank(1, 1));
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = mk_bank(9'h100, 3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_data", out_data, 9'h004);
         chk("stall_index", out_index, 3);
         chk("stall_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset mid-bank at idx 5.
      send_bank(mk_bank(9'h020, 7));
      repeat (5) begin @(posedge clk); #1; end
      chk("pre_rst_index", out_index, 5);
      rst = 1'b1;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      send_bank(mk_bank(9'h0A0, 1));
      chk("post_rst_index", out_index, 0);
      chk("post_rst_data", out_data, 9'h0A0);
      wait_idle();

      // BANK_SIZE=1 stream.
      w1[0] = 4'hA; w1[1] = 4'h5; w1[2] = 4'hF;
      in_valid1 = 1'b1; out_ready1 = 1'b1; in_data1 = w1[0];
      @(negedge clk);
      chk("bs1_ready_idle", in_ready1, 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k < 2) in_data1 = w1[k+1];
         else       in_valid1 = 1'b0;
         @(negedge clk);
         chk("bs1_valid", out_valid1, 1);
         chk("bs1_data", out_data1, w1[k]);
         chk("bs1_last", out_last1, 1);
         chk("bs1_index", out_index1, 0);
         chk("bs1_in_ready", in_ready1, 1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("bs1_idle", out_valid1, 0);

      // Random traffic on both sides.
      prod_done = 0;
      fork
         begin
            for (int b = 0; b < 1000; b++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send_bank({$urandom, $urandom, $urandom});
            end
            prod_done = 1;
         end
         begin
            while (!prod_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
